// File: rtl/angle_search.sv
// angle_search -- inverse sine/cosine: maps a SenLUT-format value back to
// an angle in degrees (0..359).
//
// A binary search over the 0..MAX_ANGLE quarter of an internal SenLUT finds
// the largest angle a with SenLUT(a) <= |value|. That angle is then unfolded
// into the full circle using the sign of value and the op selector.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, accepted only when idle
//   op_selector  0 = arcsine, 1 = arccosine
//   value        32-bit two's-complement SenLUT-format input, sampled on start
//   busy         high while a search is in flight
//   done         one-cycle pulse, angle valid
//   angle        result in degrees, held until the next done
//
// Build option: define ANGLE_SEARCH_ROUND_EN to round to the nearest table
// entry instead of flooring (adds one ROUND cycle of latency).

// SenLUT quarter wave: round(sin(deg) * 2^16) for deg 0..90, zero beyond.
module sen_lut (
  input  logic [31:0] deg,
  output logic [31:0] val
);
  localparam logic [31:0] TBL [91] = '{
        0,  1144,  2287,  3430,  4572,  5712,  6850,  7987,  9121, 10252,
    11380, 12505, 13626, 14742, 15855, 16962, 18064, 19161, 20252, 21336,
    22415, 23486, 24550, 25607, 26656, 27697, 28729, 29753, 30767, 31772,
    32768, 33754, 34729, 35693, 36647, 37590, 38521, 39441, 40348, 41243,
    42126, 42995, 43852, 44695, 45525, 46341, 47143, 47930, 48703, 49461,
    50203, 50931, 51643, 52339, 53020, 53684, 54332, 54963, 55578, 56175,
    56756, 57319, 57865, 58393, 58903, 59396, 59870, 60326, 60764, 61183,
    61584, 61966, 62328, 62672, 62997, 63303, 63589, 63856, 64104, 64332,
    64540, 64729, 64898, 65048, 65177, 65287, 65376, 65446, 65496, 65526,
    65536};

  always_comb begin
    val = 32'h0;
    if (deg <= 32'd90) val = TBL[deg[6:0]];
  end
endmodule

module angle_search #(
  parameter int ITERS     = 7,
  parameter int MAX_ANGLE = 90
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op_selector,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic [31:0] angle
);
  localparam int         CW   = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [7:0] MAXA = 8'(MAX_ANGLE);

  typedef enum logic [1:0] {IDLE, SEARCH, ROUND, RESULT} state_t;
  state_t state, nxt;

  logic          op_q, neg_q;
  logic [31:0]   mag_q, mag_in;
  logic [7:0]    lo, hi, mid;
  logic [8:0]    sum;
  logic [CW-1:0] cnt;
  logic [31:0]   angle_q, result, lut_addr, lut_val;

  // |value| with the most negative code clamped so it stays positive.
  always_comb begin
    mag_in = value;
    if (value[31]) mag_in = (value == 32'h8000_0000) ? 32'h7FFF_FFFF : 32'(-value);
  end

  // Upper midpoint so lo always advances when lo<hi.
  always_comb begin
    sum = {1'b0, lo} + {1'b0, hi} + 9'd1;
    mid = sum[8:1];
  end

  // One LUT serves both the search probe (mid) and the ROUND floor (lo).
  assign lut_addr = {24'h0, (state == SEARCH) ? mid : lo};
  sen_lut u_lut (.deg(lut_addr), .val(lut_val));

`ifdef ANGLE_SEARCH_ROUND_EN
  logic [31:0] lut_up_val;
  logic        round_up;
  sen_lut u_lut_up (.deg({24'h0, lo + 8'd1}), .val(lut_up_val));
  // lo is the floor, so lut_val <= mag < lut_up_val; ties keep the floor.
  assign round_up = (lo < MAXA) && ((mag_q - lut_val) > (lut_up_val - mag_q));
`endif

  // Unfold the quarter-wave angle by sign and op.
  always_comb begin
    if (!op_q) result = neg_q ? ((lo == 8'd0) ? 32'd0 : 32'd360 - {24'h0, lo}) : {24'h0, lo};
    else       result = neg_q ? 32'd90 + {24'h0, lo} : 32'd90 - {24'h0, lo};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (start) nxt = SEARCH;
      SEARCH: if (cnt == CW'(ITERS - 1)) begin
`ifdef ANGLE_SEARCH_ROUND_EN
                nxt = ROUND;
`else
                nxt = RESULT;
`endif
              end
      ROUND:  nxt = RESULT;
      RESULT: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs: done and the fresh result appear in the RESULT cycle itself,
  // then the registered copy holds the angle.
  always_comb begin
    busy  = (state == SEARCH) || (state == ROUND);
    done  = (state == RESULT);
    angle = done ? result : angle_q;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 1'b0;
      neg_q   <= 1'b0;
      mag_q   <= 32'h0;
      lo      <= 8'h0;
      hi      <= 8'h0;
      cnt     <= '0;
      angle_q <= 32'h0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q  <= op_selector;
          neg_q <= value[31];
          mag_q <= mag_in;
          lo    <= 8'h0;
          hi    <= MAXA;
          cnt   <= '0;
        end
        SEARCH: begin
          cnt <= cnt + 1'b1;
          if (lo < hi) begin
            if (lut_val <= mag_q) lo <= mid;
            else                  hi <= mid - 8'd1;
          end
        end
`ifdef ANGLE_SEARCH_ROUND_EN
        ROUND: if (round_up) lo <= lo + 8'd1;
`endif
        RESULT: angle_q <= result;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_angle_search.sv
// Bench for angle_search: directed vectors with literal expected angles,
// plus a per-cycle compare of busy/done/angle against a behavioural model
// (linear scan of the sine table, then unfold by sign and op).
module tb_angle_search;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op_selector = 1'b0;
  logic [31:0] value = 32'h0;
  logic        busy, done;
  logic [31:0] angle;

`ifdef ANGLE_SEARCH_ROUND_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  // round(sin(d deg) * 65536)
  localparam logic [31:0] LUT [91] = '{
        0,  1144,  2287,  3430,  4572,  5712,  6850,  7987,  9121, 10252,
    11380, 12505, 13626, 14742, 15855, 16962, 18064, 19161, 20252, 21336,
    22415, 23486, 24550, 25607, 26656, 27697, 28729, 29753, 30767, 31772,
    32768, 33754, 34729, 35693, 36647, 37590, 38521, 39441, 40348, 41243,
    42126, 42995, 43852, 44695, 45525, 46341, 47143, 47930, 48703, 49461,
    50203, 50931, 51643, 52339, 53020, 53684, 54332, 54963, 55578, 56175,
    56756, 57319, 57865, 58393, 58903, 59396, 59870, 60326, 60764, 61183,
    61584, 61966, 62328, 62672, 62997, 63303, 63589, 63856, 64104, 64332,
    64540, 64729, 64898, 65048, 65177, 65287, 65376, 65446, 65496, 65526,
    65536};

  angle_search dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_selector(op_selector),
    .value(value), .busy(busy), .done(done), .angle(angle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural answer straight from the rules: largest table angle not
  // above |value|, optional nearest rounding, then quadrant unfold.
  function automatic logic [31:0] model(input logic op, input logic [31:0] v);
    logic [31:0] mag;
    int a;
    mag = v;
    if (v[31]) mag = (v == 32'h8000_0000) ? 32'h7FFF_FFFF : 32'(-v);
    a = 0;
    for (int d = 0; d <= 90; d++) if (LUT[d] <= mag) a = d;
`ifdef ANGLE_SEARCH_ROUND_EN
    if (a < 90 && (mag - LUT[a]) > (LUT[a+1] - mag)) a = a + 1;
`endif
    if (!op) return v[31] ? ((a == 0) ? 32'd0 : 32'(360 - a)) : 32'(a);
    return v[31] ? 32'(90 + a) : 32'(90 - a);
  endfunction

  // Model timeline: m_t = cycles since acceptance (-1 when idle).
  int          m_t;
  logic [31:0] m_res, m_angle;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t     <= -1;
      m_res   <= 32'h0;
      m_angle <= 32'h0;
    end else if (m_t < 0) begin
      if (start) begin
        m_t   <= 1;
        m_res <= model(op_selector, value);
      end
    end else if (m_t == LAT) begin
      m_t <= -1;
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == LAT) m_angle <= m_res;
    end
  end

  // Per-cycle compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("busy", {31'h0, busy}, {31'h0, (m_t >= 1 && m_t < LAT)});
        chk("done", {31'h0, done}, {31'h0, (m_t == LAT)});
        chk("angle", angle, m_angle);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Issue one request, wait (bounded) for done, check latency and angle.
  task automatic go(input string nm, input logic op, input logic [31:0] v,
                    input bit lit, input logic [31:0] exp);
    int n;
    tick();
    start = 1'b1; op_selector = op; value = v;
    tick();
    start = 1'b0; op_selector = ~op; value = $urandom;  // ignored while busy
    n = 1;
    while (!done && n < 30) begin tick(); n++; end
    chk({nm, "_lat"}, n, LAT);
    if (lit) chk({nm, "_angle"}, angle, exp);
    else     chk({nm, "_angle"}, angle, model(op, v));
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_angle", angle, 32'd0);
    rst_n = 1'b1;
    tick();

    go("asin30",     1'b0, 32'd32768,      1, 32'd30);
    go("asin_n30",   1'b0, 32'hFFFF_8000,  1, 32'd330);
    go("acos_n30",   1'b1, 32'hFFFF_8000,  1, 32'd120);
    go("acos30",     1'b1, 32'd32768,      1, 32'd60);
    go("acos0",      1'b1, 32'd0,          1, 32'd90);
    go("asin0",      1'b0, 32'd0,          1, 32'd0);
    go("asin_sat",   1'b0, 32'h8000_0000,  1, 32'd270);
    go("asin_max",   1'b0, 32'h7FFF_FFFF,  1, 32'd90);
    go("asin_m1",    1'b0, 32'hFFFF_FFFF,  1, 32'd0);
    go("acos_m1",    1'b1, 32'hFFFF_FFFF,  1, 32'd90);
`ifdef ANGLE_SEARCH_ROUND_EN
    go("round44",    1'b0, 32'd45934,      1, 32'd45);
`else
    go("round44",    1'b0, 32'd45934,      1, 32'd44);
`endif
    go("below1",     1'b0, 32'd1143,       0, 32'd0);
    go("at1",        1'b1, 32'd1144,       0, 32'd0);
    go("near90",     1'b0, 32'd65535,      0, 32'd0);
    go("acos_n89",   1'b1, 32'hFFFF_0000 + 32'd10, 0, 32'd0);
    for (int i = 0; i < 6; i++)
      go("rnd", 1'($urandom), 32'($urandom_range(0, 70000)) ^ {$urandom_range(0, 1) == 1 ? 32'hFFFF_FFFF : 32'h0}, 0, 32'd0);

    // Start pulses during a search are ignored.
    tick();
    start = 1'b1; op_selector = 1'b0; value = 32'd32768;
    tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; value = 32'd65536; tick(); start = 1'b0;   // cycle 3
    repeat (4) tick();
    start = 1'b1; value = 32'd65536;                          // cycle 8
    if (LAT == 8) chk("ign_done", {31'h0, done}, 32'd1);
    tick(); start = 1'b0;
    while (busy || done) tick();
    chk("ign_angle", angle, 32'd30);
    repeat (3) tick();

    // Reset mid-search aborts without a done.
    start = 1'b1; op_selector = 1'b0; value = 32'd46341;
    tick(); start = 1'b0;
    repeat (3) tick();                                        // cycle 4
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    chk("abort_angle", angle, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("abort_quiet", angle, 32'd0);

    go("post_rst", 1'b1, 32'd56756, 1, 32'd30);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1 (bench did not finish)");
    $fatal(1);
  end
endmodule
